// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result valid-ready bundle for serial_adder.
interface serial_adder_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] o;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             negative;
    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, o, carry, overflow, zero, negative
    );
    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, o, carry, overflow, zero, negative
    );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle add/sub, CHUNK bits per clock LSB-first with registered carry,
// valid/ready on both sides and carry/overflow/zero/negative flags.
module serial_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input logic           clk,
    input logic           rst_n,
    serial_adder_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int IW = N > 1 ? $clog2(N) : 1;
    if (CHUNK < 1 || CHUNK > WIDTH || WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("serial_adder: CHUNK must divide WIDTH");
    end
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, o_q, o_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             c_q, c_d, carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d, neg_q, neg_d;
    logic [CHUNK:0]   sum;
    logic             accept, last;
    assign bus.in_ready  = state_q == IDLE || (state_q == DONE && bus.out_ready);
    assign bus.out_valid = state_q == DONE;
    assign bus.o         = o_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;
    assign bus.negative  = neg_q;
    assign accept = bus.in_valid && bus.in_ready;
    assign last   = idx_q == IW'(N - 1);
    assign sum    = {1'b0, a_q[idx_q*CHUNK +: CHUNK]} + {1'b0, b_q[idx_q*CHUNK +: CHUNK]}
                  + {{CHUNK{1'b0}}, c_q};
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        o_d     = o_q;
        idx_d   = idx_q;
        c_d     = c_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        if (state_q == BUSY) begin
            o_d[idx_q*CHUNK +: CHUNK] = sum[CHUNK-1:0];
            c_d   = sum[CHUNK];
            idx_d = idx_q + IW'(1);
            if (last) begin
                state_d = DONE;
                carry_d = sum[CHUNK];
                ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (o_d[WIDTH-1] != a_q[WIDTH-1]);
                zero_d  = o_d == '0;
                neg_d   = o_d[WIDTH-1];
            end
        end
        if (state_q == DONE && bus.out_ready) state_d = IDLE;
        // subtraction is a + ~b + 1: invert b once here and seed the carry with sub
        if (accept) begin
            state_d = BUSY;
            a_d     = bus.a;
            b_d     = bus.b ^ {WIDTH{bus.sub}};
            c_d     = bus.sub;
            idx_d   = '0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            o_q     <= '0;
            idx_q   <= '0;
            c_q     <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            o_q     <= o_d;
            idx_q   <= idx_d;
            c_q     <= c_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed table and corner sequences on a CHUNK=8 instance, then
// randomized operands on CHUNK 8/1/4/32 instances against an arithmetic reference model.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst_n;
    bit   rand_go;
    int   errs = 0;
    int   checks = 0;
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    // returns {o, carry, overflow, zero, negative} from plain integer arithmetic
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint          r;
        logic [31:0]     o;
        logic            c, v;
        o = s ? a - b : a + b;
        c = s ? ua >= ub : (ua + ub) > 64'hFFFF_FFFF;
        r = s ? sa - sb : sa + sb;
        v = r != longint'($signed(o));
        return {o, c, v, o == 32'h0, o[31]};
    endfunction
    serial_adder_if #(.WIDTH(32)) dbus ();
    serial_adder #(.WIDTH(32), .CHUNK(8)) dut (.clk(clk), .rst_n(rst_n), .bus(dbus.slave));
    for (genvar g = 0; g < 4; g++) begin : u
        localparam int C  = g == 0 ? 8 : g == 1 ? 1 : g == 2 ? 4 : 32;
        localparam int NN = 32 / C;
        serial_adder_if #(.WIDTH(32)) bus ();
        serial_adder #(.WIDTH(32), .CHUNK(C)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
        bit done;
        initial begin
            logic [31:0] ra, rb;
            logic        rs;
            logic [35:0] e;
            int          lat;
            done = 1'b0;
            bus.in_valid = 1'b0;
            bus.a = '0;
            bus.b = '0;
            bus.sub = 1'b0;
            bus.out_ready = 1'b0;
            wait (rand_go);
            @(posedge clk); #1;
            for (int k = 0; k < 300; k++) begin
                ra = $urandom;
                rb = (k % 16 == 0) ? ra : $urandom;
                rs = 1'($urandom_range(0, 1));
                e  = model(ra, rb, rs);
                chk($sformatf("c%0d_in_ready", C), 64'(bus.in_ready), 64'd1);
                bus.a = ra;
                bus.b = rb;
                bus.sub = rs;
                bus.in_valid = 1'b1;
                @(posedge clk); #1;
                bus.in_valid = 1'b0;
                bus.a = $urandom;
                bus.sub = ~rs;
                lat = 0;
                while (!bus.out_valid && lat < 100) begin
                    @(posedge clk); #1;
                    lat++;
                end
                chk($sformatf("c%0d_latency", C), 64'(lat), 64'(NN));
                chk($sformatf("c%0d_o", C), 64'(bus.o), 64'(e[35:4]));
                chk($sformatf("c%0d_flags", C),
                    64'({bus.carry, bus.overflow, bus.zero, bus.negative}), 64'(e[3:0]));
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk); #1;
                end
                chk($sformatf("c%0d_hold", C), 64'({bus.out_valid, bus.o}), 64'({1'b1, e[35:4]}));
                bus.out_ready = 1'b1;
                @(posedge clk); #1;
                bus.out_ready = 1'b0;
                repeat ($urandom_range(0, 1)) begin
                    @(posedge clk); #1;
                end
            end
            done = 1'b1;
        end
    end
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] o;
        logic [3:0]  f;
    } vec_t;
    vec_t tbl[9];
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s, output int lat);
        dbus.a = a;
        dbus.b = b;
        dbus.sub = s;
        dbus.in_valid = 1'b1;
        @(posedge clk); #1;
        dbus.in_valid = 1'b0;
        lat = 0;
        while (!dbus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask
    task automatic release_out();
        dbus.out_ready = 1'b1;
        @(posedge clk); #1;
        dbus.out_ready = 1'b0;
    endtask
    initial begin
        int lat, hits;
        tbl[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 4'b0000};
        tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b1010};
        tbl[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 4'b0101};
        tbl[3] = '{32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 4'b1010};
        tbl[4] = '{32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 4'b0001};
        tbl[5] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 4'b1100};
        tbl[6] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 4'b0010};
        tbl[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 4'b1110};
        tbl[8] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 4'b0001};
        rst_n = 1'b0;
        rand_go = 1'b0;
        dbus.in_valid = 1'b0;
        dbus.a = '0;
        dbus.b = '0;
        dbus.sub = 1'b0;
        dbus.out_ready = 1'b0;
        #12;
        chk("reset_hs", 64'({dbus.in_ready, dbus.out_valid}), 64'b10);
        chk("reset_o", 64'(dbus.o), 64'd0);
        chk("reset_flags", 64'({dbus.carry, dbus.overflow, dbus.zero, dbus.negative}), 64'd0);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) begin
            do_op(tbl[i].a, tbl[i].b, tbl[i].s, lat);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
            chk($sformatf("vec%0d_o", i), 64'(dbus.o), 64'(tbl[i].o));
            chk($sformatf("vec%0d_flags", i),
                64'({dbus.carry, dbus.overflow, dbus.zero, dbus.negative}), 64'(tbl[i].f));
            release_out();
            chk($sformatf("vec%0d_drop", i), 64'(dbus.out_valid), 64'd0);
        end
        dbus.a = 32'h0000_1234;
        dbus.b = 32'h0000_0010;
        dbus.sub = 1'b0;
        dbus.in_valid = 1'b1;
        @(posedge clk); #1;
        dbus.a = 32'hFFFF_FFFF;
        dbus.b = 32'hFFFF_FFFF;
        dbus.sub = 1'b1;
        chk("busy_in_ready", 64'(dbus.in_ready), 64'd0);
        @(posedge clk); #1;
        dbus.in_valid = 1'b0;
        lat = 1;
        while (!dbus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("busy_pulse_latency", 64'(lat), 64'd4);
        chk("busy_pulse_o", 64'(dbus.o), 64'h1244);
        dbus.a = 32'h0000_0100;
        dbus.b = 32'h0000_0001;
        dbus.sub = 1'b1;
        dbus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stall%0d_in_ready", i), 64'(dbus.in_ready), 64'd0);
            chk($sformatf("stall%0d_hold", i),
                64'({dbus.out_valid, dbus.o, dbus.carry, dbus.overflow, dbus.zero, dbus.negative}),
                64'({1'b1, 32'h1244, 4'b0000}));
            @(posedge clk); #1;
        end
        dbus.out_ready = 1'b1;
        #1;
        chk("b2b_in_ready", 64'(dbus.in_ready), 64'd1);
        @(posedge clk); #1;
        dbus.out_ready = 1'b0;
        dbus.in_valid = 1'b0;
        chk("b2b_drop", 64'(dbus.out_valid), 64'd0);
        lat = 0;
        while (!dbus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("b2b_latency", 64'(lat), 64'd4);
        chk("b2b_o", 64'(dbus.o), 64'h0000_00FF);
        chk("b2b_flags", 64'({dbus.carry, dbus.overflow, dbus.zero, dbus.negative}), 64'b1000);
        release_out();
        dbus.a = 32'h0000_0005;
        dbus.b = 32'h0000_0003;
        dbus.sub = 1'b0;
        dbus.in_valid = 1'b1;
        @(posedge clk); #1;
        dbus.in_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("abort_o", 64'(dbus.o), 64'd0);
        chk("abort_hs", 64'({dbus.in_ready, dbus.out_valid}), 64'b10);
        #3 rst_n = 1'b1;
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (dbus.out_valid) hits++;
        end
        chk("abort_no_result", 64'(hits), 64'd0);
        chk("abort_in_ready", 64'(dbus.in_ready), 64'd1);
        rand_go = 1'b1;
        for (int t = 0; t < 30000 && !(u[0].done && u[1].done && u[2].done && u[3].done); t++)
            @(posedge clk);
        chk("rand_done", 64'({u[0].done, u[1].done, u[2].done, u[3].done}), 64'b1111);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
